load_store_unit: RTL and testbench

Memory-stage load/store unit that consumes the effective address and the low-address/misalignment code from the address generator. It performs byte-serial accesses to a byte-wide synchronous data memory and returns sign- or zero-extended load data to the pipeline. It sits between the execute-stage address generator and the data RAM, and uses a single-request valid/ready handshake with a one-cycle completion pulse.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_if.sv | 45 ++++
 rtl/lsu_load_extend.sv | 29 ++
 rtl/load_store_unit.sv | 126 ++++++++++++
 tb/tb_load_store_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit.
//   SIZE_BYTE / SIZE_HALF / SIZE_WORD : access size encodings (2'b11 acts as word)
//   lsu_state_t                       : FSM state encoding
//   byte_count()                      : number of bytes moved for a given size
// ----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DRAIN  = 2'b10,
        DONE   = 2'b11
    } lsu_state_t;

    // Any size code other than byte/half moves four bytes.
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            SIZE_BYTE: byte_count = 3'd1;
            SIZE_HALF: byte_count = 3'd2;
            default:   byte_count = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// ----------------------------------------------------------------------------
// lsu_if
// Bundles the pipeline request/response handshake and the byte-wide data RAM
// port of the load/store unit.
//   slave  : the load/store unit side
//   master : the environment side (pipeline + RAM)
// Request : i_valid, o_ready, i_we, i_size, i_unsigned, i_eff_addr,
//           i_addr_exception, i_wdata
// Response: o_done, o_fault, o_rdata
// RAM     : o_mem_addr, o_mem_we, o_mem_wdata, i_mem_rdata
// ----------------------------------------------------------------------------
interface lsu_if #(
    parameter int ADDR_W = 10
);
    logic              i_valid;
    logic              o_ready;
    logic              i_we;
    logic [1:0]        i_size;
    logic              i_unsigned;
    logic [31:0]       i_eff_addr;
    logic [1:0]        i_addr_exception;
    logic [31:0]       i_wdata;
    logic              o_done;
    logic              o_fault;
    logic [31:0]       o_rdata;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_we;
    logic [7:0]        o_mem_wdata;
    logic [7:0]        i_mem_rdata;

    modport slave (
        input  i_valid, i_we, i_size, i_unsigned, i_eff_addr,
               i_addr_exception, i_wdata, i_mem_rdata,
        output o_ready, o_done, o_fault, o_rdata,
               o_mem_addr, o_mem_we, o_mem_wdata
    );

    modport master (
        output i_valid, i_we, i_size, i_unsigned, i_eff_addr,
               i_addr_exception, i_wdata, i_mem_rdata,
        input  o_ready, o_done, o_fault, o_rdata,
               o_mem_addr, o_mem_we, o_mem_wdata
    );

endinterface

// File: rtl/lsu_load_extend.sv
// ----------------------------------------------------------------------------
// lsu_load_extend
// Combinational sign/zero extension of assembled load data.
//   lanes       in  32  little-endian bytes gathered from memory
//   size        in  2   access size code
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   result      out 32  extended load value
// ----------------------------------------------------------------------------
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] lanes,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    always_comb begin
        result = lanes;
        case (size)
            SIZE_BYTE: result = is_unsigned ? {24'h000000, lanes[7:0]}
                                            : {{24{lanes[7]}}, lanes[7:0]};
            SIZE_HALF: result = is_unsigned ? {16'h0000, lanes[15:0]}
                                            : {{16{lanes[15]}}, lanes[15:0]};
            default:   result = lanes;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
// Memory-stage unit that performs byte-serial loads and stores against a
// byte-wide synchronous RAM and returns extended load data.
//   i_clk   in  clock
//   i_rst_n in  synchronous active-low reset
//   bus     lsu_if.slave : request handshake, response, RAM port
// Optional feature: define LSU_ALIGN_CHECK_EN to reject misaligned half/word
// requests with o_fault instead of performing them byte-serially.
// ----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    lsu_if.slave  bus
);

    lsu_state_t        state, state_next;
    logic [ADDR_W-1:0] base_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              uns_q;
    logic [31:0]       wdata_q;
    logic [1:0]        cnt_q;
    logic [1:0]        cap_idx_q;
    logic              cap_vld_q;
    logic [31:0]       lanes_q;
    logic [31:0]       lanes_merged;
    logic [31:0]       ext_data;
    logic [31:0]       rdata_q;
    logic              fault_q;
    logic              accept;
    logic              misaligned;
    logic              last_beat;
    logic              access_live;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^bus.i_eff_addr[31:ADDR_W];

    assign accept    = bus.i_valid && (state == IDLE);
    assign last_beat = ({1'b0, cnt_q} == (byte_count(size_q) - 3'd1));

`ifdef LSU_ALIGN_CHECK_EN
    assign misaligned = ((bus.i_size == SIZE_HALF) && bus.i_addr_exception[0]) ||
                        ((bus.i_size[1] == 1'b1) && (bus.i_addr_exception != 2'b00));
`else
    logic unused_exc;
    assign unused_exc = ^bus.i_addr_exception;
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = misaligned ? DONE : ACCESS;
            ACCESS:  if (last_beat) state_next = we_q ? DONE : DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // RAM data arrives one cycle after its address, so the byte requested in
    // the previous cycle is merged into its lane here; DRAIN uses this merged
    // view to pick up the final byte in the same cycle it lands.
    always_comb begin
        lanes_merged = lanes_q;
        if (cap_vld_q) lanes_merged[{cap_idx_q, 3'b000} +: 8] = bus.i_mem_rdata;
    end

    lsu_load_extend u_extend (
        .lanes       (lanes_merged),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (ext_data)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            base_q    <= '0;
            size_q    <= SIZE_BYTE;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            cap_idx_q <= '0;
            cap_vld_q <= 1'b0;
            lanes_q   <= '0;
            rdata_q   <= '0;
            fault_q   <= 1'b0;
        end else begin
            state     <= state_next;
            cap_vld_q <= (state == ACCESS) && !we_q;
            cap_idx_q <= cnt_q;
            lanes_q   <= lanes_merged;
            if (state == ACCESS) cnt_q <= cnt_q + 2'd1;
            if (state == DRAIN)  rdata_q <= ext_data;
            if (accept) begin
                base_q  <= bus.i_eff_addr[ADDR_W-1:0];
                size_q  <= bus.i_size;
                we_q    <= bus.i_we;
                uns_q   <= bus.i_unsigned;
                wdata_q <= bus.i_wdata;
                cnt_q   <= '0;
                lanes_q <= '0;
                fault_q <= misaligned;
            end
        end
    end

    // RAM strobes and o_done are masked while reset is asserted so an aborted
    // request issues no further write or completion in the reset cycle itself.
    assign access_live     = (state == ACCESS) && i_rst_n;
    assign bus.o_ready     = (state == IDLE);
    assign bus.o_done      = (state == DONE) && i_rst_n;
    assign bus.o_fault     = fault_q;
    assign bus.o_rdata     = rdata_q;
    assign bus.o_mem_addr  = access_live ? (base_q + ADDR_W'(cnt_q)) : '0;
    assign bus.o_mem_we    = access_live && we_q;
    assign bus.o_mem_wdata = (access_live && we_q) ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit with a byte-wide synchronous RAM model.
// ----------------------------------------------------------------------------
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int ADDR_W = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    lsu_if #(.ADDR_W(ADDR_W)) bus ();

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    logic [7:0]        mem [0:(1<<ADDR_W)-1];
    logic              pre_we   = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [7:0]        pre_data = 8'h00;

    // Synchronous RAM: read data follows the address by one cycle; the
    // preload port lets the bench seed contents while the unit is idle.
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.o_mem_we) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
        bus.i_mem_rdata <= mem[bus.o_mem_addr];
    end

    int          checks = 0;
    int          passes = 0;
    int          done_cyc;
    int          addr_hits;
    int          done_count;
    logic [31:0] we_mask;
    logic [31:0] res_rdata;
    logic        res_fault;

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Presents one request in cycle 0, then watches cycles 1..12 for write
    // strobes, address activity and the completion pulse.
    task automatic applyStimulus(input logic we, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr,
                                 input logic [1:0] exc, input logic [31:0] wdata);
        @(negedge clk);
        bus.i_valid          = 1'b1;
        bus.i_we             = we;
        bus.i_size           = size;
        bus.i_unsigned       = uns;
        bus.i_eff_addr       = addr;
        bus.i_addr_exception = exc;
        bus.i_wdata          = wdata;
        done_cyc  = -1;
        addr_hits = 0;
        we_mask   = '0;
        res_rdata = '0;
        res_fault = 1'b0;
        @(posedge clk);
        for (int cyc = 1; cyc <= 12 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            if (bus.o_mem_we) we_mask[cyc] = 1'b1;
            if (bus.o_mem_addr != '0) addr_hits++;
            if (bus.o_done) begin
                done_cyc  = cyc;
                res_rdata = bus.o_rdata;
                res_fault = bus.o_fault;
            end
        end
    endtask

    initial begin
        bus.i_valid          = 1'b0;
        bus.i_we             = 1'b0;
        bus.i_size           = SIZE_BYTE;
        bus.i_unsigned       = 1'b0;
        bus.i_eff_addr       = '0;
        bus.i_addr_exception = 2'b00;
        bus.i_wdata          = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_ready",  {31'd0, bus.o_ready},    32'd1);
        checkOutput("rst_done",   {31'd0, bus.o_done},     32'd0);
        checkOutput("rst_fault",  {31'd0, bus.o_fault},    32'd0);
        checkOutput("rst_rdata",  bus.o_rdata,             32'd0);
        checkOutput("rst_maddr",  32'(bus.o_mem_addr),     32'd0);
        checkOutput("rst_mwe",    {31'd0, bus.o_mem_we},   32'd0);
        checkOutput("rst_mwdata", {24'd0, bus.o_mem_wdata}, 32'd0);

        preload(10'h010, 8'h80);
        preload(10'h011, 8'h01);
        preload(10'h012, 8'h02);
        preload(10'h013, 8'h03);
        preload(10'h014, 8'h80);
        preload(10'h040, 8'h11);
        preload(10'h041, 8'h22);
        preload(10'h042, 8'h33);
        preload(10'h043, 8'h44);

        applyStimulus(1'b0, SIZE_WORD, 1'b0, 32'h10, 2'b00, 32'h0);
        checkOutput("lw_rdata", res_rdata, 32'h03020180);
        checkOutput("lw_done",  32'(done_cyc), 32'd6);
        checkOutput("lw_we",    we_mask, 32'h0);
        checkOutput("lw_fault", {31'd0, res_fault}, 32'd0);

        applyStimulus(1'b0, SIZE_BYTE, 1'b0, 32'h10, 2'b00, 32'h0);
        checkOutput("lb_rdata", res_rdata, 32'hFFFFFF80);
        checkOutput("lb_done",  32'(done_cyc), 32'd3);

        applyStimulus(1'b0, SIZE_BYTE, 1'b1, 32'h10, 2'b00, 32'h0);
        checkOutput("lbu_rdata", res_rdata, 32'h00000080);

        applyStimulus(1'b0, SIZE_HALF, 1'b0, 32'h13, 2'b00, 32'h0);
        checkOutput("lh_rdata", res_rdata, 32'hFFFF8003);
        checkOutput("lh_done",  32'(done_cyc), 32'd4);

        applyStimulus(1'b0, SIZE_HALF, 1'b1, 32'h13, 2'b00, 32'h0);
        checkOutput("lhu_rdata", res_rdata, 32'h00008003);

        applyStimulus(1'b1, SIZE_HALF, 1'b0, 32'h20, 2'b00, 32'h0000BEEF);
        checkOutput("sh_mem20", {24'd0, mem[10'h020]}, 32'h000000EF);
        checkOutput("sh_mem21", {24'd0, mem[10'h021]}, 32'h000000BE);
        checkOutput("sh_we",    we_mask, 32'h00000006);
        checkOutput("sh_done",  32'(done_cyc), 32'd3);
        checkOutput("sh_rdata", res_rdata, 32'h00008003);

        applyStimulus(1'b0, SIZE_WORD, 1'b0, 32'h11, 2'b01, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
        checkOutput("mis_fault", {31'd0, res_fault}, 32'd1);
        checkOutput("mis_done",  32'(done_cyc), 32'd1);
        checkOutput("mis_addr",  32'(addr_hits), 32'd0);
        checkOutput("mis_rdata", res_rdata, 32'h00008003);
`else
        checkOutput("mis_rdata", res_rdata, 32'h80030201);
        checkOutput("mis_done",  32'(done_cyc), 32'd6);
        checkOutput("mis_fault", {31'd0, res_fault}, 32'd0);
`endif

        applyStimulus(1'b1, SIZE_WORD, 1'b0, 32'h3FE, 2'b10, 32'h11223344);
        checkOutput("wrap_3fe",  {24'd0, mem[10'h3FE]}, 32'h00000044);
        checkOutput("wrap_3ff",  {24'd0, mem[10'h3FF]}, 32'h00000033);
        checkOutput("wrap_000",  {24'd0, mem[10'h000]}, 32'h00000022);
        checkOutput("wrap_001",  {24'd0, mem[10'h001]}, 32'h00000011);
        checkOutput("wrap_we",   we_mask, 32'h0000001E);
        checkOutput("wrap_done", 32'(done_cyc), 32'd5);

        // Store word aborted by reset asserted during cycle 2.
        @(negedge clk);
        bus.i_valid          = 1'b1;
        bus.i_we             = 1'b1;
        bus.i_size           = SIZE_WORD;
        bus.i_unsigned       = 1'b0;
        bus.i_eff_addr       = 32'h40;
        bus.i_addr_exception = 2'b00;
        bus.i_wdata          = 32'hAABBCCDD;
        done_count           = 0;
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        if (bus.o_done) done_count++;
        @(negedge clk);
        rst_n = 1'b0;
        if (bus.o_done) done_count++;
        @(negedge clk);
        rst_n = 1'b1;
        if (bus.o_done) done_count++;
        @(negedge clk);
        checkOutput("abort_ready", {31'd0, bus.o_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.o_done) done_count++;
        end
        checkOutput("abort_done",  32'(done_count), 32'd0);
        checkOutput("abort_mem40", {24'd0, mem[10'h040]}, 32'h000000DD);
        checkOutput("abort_mem41", {24'd0, mem[10'h041]}, 32'h00000022);
        checkOutput("abort_mem42", {24'd0, mem[10'h042]}, 32'h00000033);
        checkOutput("abort_mem43", {24'd0, mem[10'h043]}, 32'h00000044);

        applyStimulus(1'b0, SIZE_BYTE, 1'b1, 32'h40, 2'b00, 32'h0);
        checkOutput("post_rdata", res_rdata, 32'h000000DD);
        checkOutput("post_done",  32'(done_cyc), 32'd3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
